mod_counter_updown: RTL
=======================

Name: mod_counter_updown

Overview:
Parametrised mod-(FINAL_VALUE+1) counter, successor to the basic up-only mod counter. Counts 0..FINAL_VALUE in either direction, with synchronous clear, synchronous parallel load and a selectable wrap or saturate policy. Emits a terminal-count flag, a registered wrap tick and a running wrap-event count. Used as a timebase, digit counter or cascade stage in timer/display blocks: one stage's tick drives the next stage's enable.

Parameters:
FINAL_VALUE, 9, terminal count; legal range 1..2^16-1; counter cycles through FINAL_VALUE+1 states.
SATURATE, 0, 0 = wrap at terminal, 1 = hold at terminal.
WRAP_CNT_BITS, 8, width of wrap_count.
BITS, $clog2(FINAL_VALUE+1), derived localparam (not overridable); width of Q and load_value.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  synchronous active-low reset, sampled on rising clk.
enable  input  1  count-step enable.
up  input  1  direction: 1 = increment, 0 = decrement.
clear  input  1  synchronous clear of Q to 0.
load  input  1  synchronous parallel load.
load_value  input  BITS  value for load.
Q  output  BITS  current count (registered).
done  output  1  terminal-count flag (combinational from Q and up).
tick  output  1  registered one-cycle wrap pulse.
wrap_count  output  WRAP_CNT_BITS  number of wraps since reset/clear (registered).
load_err  output  1  registered one-cycle pulse: out-of-range load.

Behaviour:
- Reset, sampled at a rising clk with reset_n=0: Q=0, tick=0, wrap_count=0, load_err=0. done then reflects Q=0 for the current up value.
- Per-cycle priority: reset_n > clear > load > enable. Nothing happens when none is active: Q holds and tick=0.
- clear: Q<=0, wrap_count<=0, tick<=0, load_err<=0. Ignores load and enable in the same cycle.
- load, without clear:
  - load_value <= FINAL_VALUE: Q<=load_value.
  - load_value > FINAL_VALUE: Q<=FINAL_VALUE and load_err<=1 for one cycle.
  - Load never causes tick. Load overrides enable in the same cycle.
- enable, without clear or load:
  - up=1, Q<FINAL_VALUE: Q<=Q+1.
  - up=1, Q==FINAL_VALUE: wrap mode: Q<=0. Saturate mode: Q holds.
  - up=0, Q>0: Q<=Q-1.
  - up=0, Q==0: wrap mode: Q<=FINAL_VALUE. Saturate mode: Q holds.
- wrap event: enable step at a terminal (Q==FINAL_VALUE with up=1, or Q==0 with up=0) while SATURATE=0.
  - tick=1 in the cycle after the wrap edge, for exactly one cycle.
  - wrap_count increments on the same edge Q wraps.
  - wrap_count rolls over from 2^WRAP_CNT_BITS-1 to 0 silently.
  - With SATURATE=1, tick stays 0 and wrap_count stays 0.
- done = (up ? Q==FINAL_VALUE : Q==0).
  - Combinational; toggling up changes done in the same cycle.
  - In saturate mode, done stays high while held.
- Direction change mid-count: takes effect on the next enabled edge with no lost or extra step.
- Arithmetic: BITS-wide, no unsigned under/overflow ever reaches Q. Compare against FINAL_VALUE, not 2^BITS-1, so non-power-of-two ranges are exact.
- reset_n low while enable/load are active: reset wins. The first enable edge after reset release counts from 0.
- Latency:
  - Q updates one edge after the qualifying input.
  - tick and load_err are registered, one cycle after the causing edge.

Decomposition:
- Shared package mod_counter_pkg:
  - function clog2_states(n) returning $clog2(n+1), with a minimum of 1;
  - localparams WRAP=0 and SAT=1 for the SATURATE encoding.
- Sub-module wrap_event_counter:
  - free-running WRAP_CNT_BITS-bit counter with enable and sync clear;
  - instantiated once, enable = wrap event, clear = clear.
- Counter core, load clamp and tick register stay in the top level.

Test Plan:
- Defaults, reset, then enable=1, up=1 for 12 cycles -> Q sequence 0..9,0,1,2. tick high in the cycle after Q 9->0. wrap_count=1. done high only when Q=9.
- up=0 from Q=2, enable 4 cycles -> Q 2,1,0,9,8. tick one cycle after 0->9. done high at Q=0 while up=0.
- load=1, load_value=12 (BITS=4) -> Q=9, load_err pulse 1 cycle, no tick. Then load_value=5 -> Q=5, load_err=0.
- Simultaneous clear=1, load=1, enable=1 at Q=7, wrap_count=3 -> Q=0, wrap_count=0, tick=0. Then load and enable together at Q=0 -> load wins.
- SATURATE=1, up=1, enable held 15 cycles from 0 -> Q stops at 9, done stays 1, tick never asserted, wrap_count=0. Then up=0 -> counts down to 0 and holds.
- WRAP_CNT_BITS=2, 5 full up cycles -> wrap_count 1,2,3,0,1. reset_n=0 mid-count with enable=1 -> Q=0, wrap_count=0 on the next edge.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared definitions for the up/down modulo counter family.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package mod_counter_pkg;

    // Encodings for the SATURATE parameter
    localparam int WRAP = 0;
    localparam int SAT  = 1;

    // Bits needed to hold the states 0..n, never less than one
    function automatic int clog2_states(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wrap_event_counter.sv
// Free-running event counter with enable and synchronous clear; rolls over silently.
// Latency: count updates on the edge where en_i is sampled high.
// Backpressure: none; every enabled cycle is counted.
module wrap_event_counter
    import mod_counter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority over the increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mod_counter_updown.sv
// Up/down modulo-(FINAL_VALUE+1) counter with clear, clamped load, wrap/saturate, wrap tick and count.
// Latency: Q, tick, load_err, wrap_count one edge after the causing input; done is combinational.
// Backpressure: none; enable is a per-cycle step request and is never stalled.
module mod_counter_updown
    import mod_counter_pkg::*;
#(
    parameter  int FINAL_VALUE   = 9,
    parameter  int SATURATE      = 0,
    parameter  int WRAP_CNT_BITS = 8,
    localparam int BITS          = clog2_states(FINAL_VALUE)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     up,
    input  logic                     clear,
    input  logic                     load,
    input  logic [BITS-1:0]          load_value,
    output logic [BITS-1:0]          Q,
    output logic                     done,
    output logic                     tick,
    output logic [WRAP_CNT_BITS-1:0] wrap_count,
    output logic                     load_err
);

    localparam logic [BITS-1:0] FINAL_Q  = BITS'(FINAL_VALUE);
    localparam bit              SAT_MODE = (SATURATE == SAT);

    logic [BITS-1:0] q_q, q_d;
    logic            tick_q, tick_d;
    logic            lerr_q, lerr_d;
    logic            at_max, at_zero, at_term;
    logic            step_vld;
    logic            wrap_evt;

    // Terminal detection compares against FINAL_VALUE so non-power-of-two ranges are exact
    always_comb begin
        at_max   = (q_q == FINAL_Q);
        at_zero  = (q_q == '0);
        at_term  = up ? at_max : at_zero;
        step_vld = enable && !clear && !load;
        wrap_evt = step_vld && at_term && !SAT_MODE;
    end

    // Next-state: clear > load > enable; terminal steps wrap or hold, never under/overflow
    always_comb begin
        q_d    = q_q;
        tick_d = 1'b0;
        lerr_d = 1'b0;
        if (clear) begin
            q_d = '0;
        end else if (load) begin
            if (load_value > FINAL_Q) begin
                q_d    = FINAL_Q;
                lerr_d = 1'b1;
            end else begin
                q_d = load_value;
            end
        end else if (enable) begin
            if (up) begin
                if (!at_max) begin
                    q_d = q_q + BITS'(1);
                end else if (!SAT_MODE) begin
                    q_d = '0;
                end
            end else begin
                if (!at_zero) begin
                    q_d = q_q - BITS'(1);
                end else if (!SAT_MODE) begin
                    q_d = FINAL_Q;
                end
            end
            tick_d = wrap_evt;
        end
    end

    // Count, tick and load-error registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q    <= '0;
            tick_q <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            tick_q <= tick_d;
            lerr_q <= lerr_d;
        end
    end

    wrap_event_counter #(
        .W (WRAP_CNT_BITS)
    ) u_wrap_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (wrap_evt),
        .clr_i   (clear),
        .cnt_o   (wrap_count)
    );

    assign Q        = q_q;
    assign done     = at_term;
    assign tick     = tick_q;
    assign load_err = lerr_q;

endmodule
